// File: rtl/serial_adder_pkg.sv
// Shared FSM encoding and sizing helpers for the bit-serial adder.
// Benches import this package to decode the state register.
package serial_adder_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One bit wider than the index range so the counter can hold WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder slice.
// Latency: purely combinational.
// Backpressure: none; no handshake on this slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder evaluation per clock, LSB first.
// Latency: WIDTH busy cycles after the accepting edge, then a one-cycle done pulse.
// Backpressure: start is ignored while busy; accepted again in IDLE or DONE.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             last_bit;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_r;
    logic             carry_ff;
    logic             cout_r;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .a         (a_sr[0]),
        .b         (b_sr[0]),
        .carry_in  (carry_ff),
        .sum       (fa_sum),
        .carry_out (fa_cout)
    );

    assign last_bit = (cnt == LAST);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    load      = 1'b1;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Back-to-back accept: a start seen during the done pulse loads immediately.
                if (start) begin
                    state_nxt = SHIFT;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            sum_r    <= '0;
            carry_ff <= 1'b0;
            cout_r   <= 1'b0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                a_sr     <= a;
                b_sr     <= b;
                carry_ff <= carry_in;
                cnt      <= '0;
                sum_r    <= '0;
            end else if (state == SHIFT) begin
                a_sr     <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr     <= {1'b0, b_sr[WIDTH-1:1]};
                sum_r    <= {fa_sum, sum_r[WIDTH-1:1]};
                carry_ff <= fa_cout;
                cnt      <= cnt + 1'b1;
                // The final carry is only published alongside the completed sum.
                if (last_bit) begin
                    cout_r <= fa_cout;
                end
            end
        end
    end

    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign sum       = sum_r;
    assign carry_out = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       carry_in;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry_out;

    int total;
    int passed;

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge; afterwards scramble the operands.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ici);
        a        = ia;
        b        = ib;
        carry_in = ici;
        start    = 1'b1;
        step();
        start    = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        carry_in = 1'($urandom);
    endtask

    // Entered in cycle 1 of an operation; returns in the done cycle (cycle 9).
    task automatic body(input string tag, input logic [7:0] es, input logic eco, input int glitch);
        for (int i = 1; i <= 8; i++) begin
            check({tag, " busy/done cycle"}, {14'd0, busy, done}, 16'h0002);
            if (i == glitch) begin
                start = 1'b1;
                a     = 8'h01;
                b     = 8'h01;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        check({tag, " done"},      {15'd0, done},      16'h0001);
        check({tag, " busy off"},  {15'd0, busy},      16'h0000);
        check({tag, " sum"},       {8'd0, sum},        {8'd0, es});
        check({tag, " carry_out"}, {15'd0, carry_out}, {15'd0, eco});
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rci;
        logic [8:0] rexp;
        int         pulses;

        total    = 0;
        passed   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        carry_in = 1'b0;

        #1 rst = 1'b1;
        #1;
        check("reset busy",      {15'd0, busy},      16'h0000);
        check("reset done",      {15'd0, done},      16'h0000);
        check("reset sum",       {8'd0, sum},        16'h0000);
        check("reset carry_out", {15'd0, carry_out}, 16'h0000);
        @(posedge clk);
        step();
        rst = 1'b0;

        // 0x0F + 0x01, done exactly in cycle 9, then held after the pulse
        issue(8'h0F, 8'h01, 1'b0);
        body("t0f01", 8'h10, 1'b0, 0);
        step();
        check("t0f01 done low after",  {15'd0, done}, 16'h0000);
        check("t0f01 sum held",        {8'd0, sum},   16'h0010);

        // Overflow cases
        issue(8'hFF, 8'h01, 1'b0);
        body("tff01", 8'h00, 1'b1, 0);
        step();
        issue(8'hFF, 8'h00, 1'b1);
        body("tff00c", 8'h00, 1'b1, 0);
        step();

        // Async reset mid-operation: carry_out was 1 and the partial sum is nonzero
        issue(8'hFF, 8'hFF, 1'b1);
        for (int i = 0; i < 4; i++) step();
        #2 rst = 1'b1;
        #1;
        check("abort busy",      {15'd0, busy},      16'h0000);
        check("abort done",      {15'd0, done},      16'h0000);
        check("abort sum",       {8'd0, sum},        16'h0000);
        check("abort carry_out", {15'd0, carry_out}, 16'h0000);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) pulses++;
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) pulses++;
        end
        check("abort no done pulse", 16'(pulses), 16'h0000);
        issue(8'h3C, 8'h0B, 1'b1);
        body("after abort", 8'h48, 1'b0, 0);
        step();

        // Start during SHIFT is ignored
        issue(8'hA5, 8'h5A, 1'b0);
        body("ignore start", 8'hFF, 1'b0, 3);
        step();
        check("ignore start idle", {15'd0, busy}, 16'h0000);

        // Back-to-back accept in the DONE cycle
        issue(8'h80, 8'h80, 1'b0);
        body("b2b first", 8'h00, 1'b1, 0);
        issue(8'h03, 8'h04, 1'b0);
        body("b2b second", 8'h07, 1'b0, 0);
        step();

        // Random operands against an integer model
        for (int n = 0; n < 1000; n++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rci  = 1'($urandom);
            rexp = {1'b0, ra} + {1'b0, rb} + {8'd0, rci};
            issue(ra, rb, rci);
            for (int i = 1; i <= 8; i++) step();
            check("rand done",   {15'd0, done},           16'h0001);
            check("rand result", {7'd0, carry_out, sum},  {7'd0, rexp});
            if ((n % 3) != 0) step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
